// File: rtl/mem_init_pkg.sv
// Shared types and the data-pattern generator for the memory traffic initiator.
package mem_init_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;
  typedef enum logic [1:0] {MODE_WR, MODE_RD, MODE_WR_RD} mode_e;

  localparam int PAT_W = 32;

  // Callers zero-extend the address and seed and truncate the result to the bus width.
  function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] addr,
                                               input logic [PAT_W-1:0] seed);
    return seed + addr;
  endfunction

  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b00:   return MODE_WR;
      2'b01:   return MODE_RD;
      default: return MODE_WR_RD;
    endcase
  endfunction

endpackage

// File: rtl/mem_init_checker.sv
// Read-back checker: compares accepted read data with the expected pattern and keeps a
// saturating mismatch count plus the address of the first mismatch.
module mem_init_checker #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  acc_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [DATA_WIDTH-1:0] expect_i,
  output logic [ADDR_WIDTH:0]   err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  output logic                  clean_o
);

  logic [ADDR_WIDTH:0]   err_cnt_q;
  logic [ADDR_WIDTH-1:0] first_err_addr_q;
  logic                  mismatch;

  assign mismatch = acc_i && (rdata_i != expect_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_cnt_q        <= '0;
      first_err_addr_q <= '0;
    end else if (clr_i) begin
      err_cnt_q        <= '0;
      first_err_addr_q <= '0;
    end else if (mismatch) begin
      if (!(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
      // The count never returns to zero without a clear, so zero marks the first error.
      if (err_cnt_q == '0) first_err_addr_q <= addr_i;
    end
  end

  // Lets the initiator compute pass in the same edge as the final read's comparison.
  assign clean_o          = (err_cnt_q == '0) && !mismatch;
  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_err_addr_q;

endmodule

// File: rtl/mem_traffic_initiator.sv
// Valid/ready memory initiator: writes seed+addr over a range, reads it back and checks it.
// Define MEM_INIT_TIMEOUT_EN to abort a request after TIMEOUT_CYCLES stalled cycles (timeout_o).
module mem_traffic_initiator
  import mem_init_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
`ifdef MEM_INIT_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  wr_rd_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [ADDR_WIDTH:0]   err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o
`ifdef MEM_INIT_TIMEOUT_EN
  , output logic                timeout_o
`endif
);

  state_e                state_q;
  mode_e                 mode_q;
  logic [ADDR_WIDTH-1:0] base_q, addr_q, addr_nxt;
  logic [ADDR_WIDTH:0]   len_q, cnt_q;
  logic [DATA_WIDTH-1:0] seed_q, wdata_q, expect_d;
  logic                  wr_rd_q, valid_q, busy_q, done_q, pass_q;
  logic                  chk_clr, chk_acc, chk_clean;

  function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a,
                                                input logic [DATA_WIDTH-1:0] s);
    return DATA_WIDTH'(pattern(PAT_W'(a), PAT_W'(s)));
  endfunction

`ifdef MEM_INIT_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_q;
  logic              timeout_q;
  assign timeout_o = timeout_q;
`endif

  assign addr_nxt = addr_q + 1'b1;
  assign expect_d = pat(addr_q, seed_q);
  assign chk_clr  = (state_q == IDLE) && start_i;
  assign chk_acc  = (state_q == READ) && valid_q && ready_i;

  mem_init_checker #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_checker (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .clr_i            (chk_clr),
    .acc_i            (chk_acc),
    .addr_i           (addr_q),
    .rdata_i          (rdata_i),
    .expect_i         (expect_d),
    .err_cnt_o        (err_cnt_o),
    .first_err_addr_o (first_err_addr_o),
    .clean_o          (chk_clean)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      mode_q  <= MODE_WR;
      base_q  <= '0;
      len_q   <= '0;
      seed_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_rd_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef MEM_INIT_TIMEOUT_EN
      wait_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            mode_q <= decode_mode(mode_i);
            base_q <= base_addr_i;
            len_q  <= len_i;
            seed_q <= seed_i;
            busy_q <= 1'b1;
            pass_q <= 1'b0;
`ifdef MEM_INIT_TIMEOUT_EN
            wait_q    <= '0;
            timeout_q <= 1'b0;
`endif
            if (len_i == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              valid_q <= 1'b1;
              addr_q  <= base_addr_i;
              cnt_q   <= len_i;
              if (decode_mode(mode_i) == MODE_RD) begin
                state_q <= READ;
                wr_rd_q <= 1'b0;
                wdata_q <= '0;
              end else begin
                state_q <= WRITE;
                wr_rd_q <= 1'b1;
                wdata_q <= pat(base_addr_i, seed_i);
              end
            end
          end
        end
        WRITE, READ: begin
          if (valid_q && ready_i) begin
`ifdef MEM_INIT_TIMEOUT_EN
            wait_q <= '0;
`endif
            if (cnt_q == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
              if (state_q == WRITE && mode_q != MODE_WR) begin
                // Read-back phase restarts at the base with the request already presented.
                state_q <= READ;
                addr_q  <= base_q;
                cnt_q   <= len_q;
                wr_rd_q <= 1'b0;
                wdata_q <= '0;
              end else begin
                state_q <= DONE;
                valid_q <= 1'b0;
                done_q  <= 1'b1;
                pass_q  <= chk_clean;
              end
            end else begin
              addr_q <= addr_nxt;
              cnt_q  <= cnt_q - 1'b1;
              if (state_q == WRITE) wdata_q <= pat(addr_nxt, seed_q);
            end
          end
`ifdef MEM_INIT_TIMEOUT_EN
          else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
            state_q   <= DONE;
            valid_q   <= 1'b0;
            done_q    <= 1'b1;
            pass_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
`endif
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign wr_rd_o = wr_rd_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign pass_o  = pass_q;

endmodule

// File: tb/tb_mem_traffic_initiator.sv
// Directed self-checking bench for mem_traffic_initiator with a small behavioural memory.
module tb_mem_traffic_initiator;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  mode_i = 2'b00;
  logic [3:0]  base_addr_i = 4'h0;
  logic [4:0]  len_i = 5'd0;
  logic [15:0] seed_i = 16'h0;
  logic [3:0]  addr_o;
  logic [15:0] wdata_o;
  logic        wr_rd_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [15:0] rdata_i;
  logic        busy_o, done_o, pass_o;
  logic [4:0]  err_cnt_o;
  logic [3:0]  first_err_addr_o;
`ifdef MEM_INIT_TIMEOUT_EN
  logic        timeout_o;
`endif

  int n_checks = 0;
  int n_fail = 0;

  // Memory model: writable array, or a fixed image (word a holds a, word 5 corrupted).
  logic [15:0] mem [16];
  logic        img_mode = 1'b0;
  logic [3:0]  log_addr [$];
  logic        log_wr   [$];
  logic [15:0] log_data [$];
  int          valid_cnt = 0;

  assign rdata_i = img_mode ? ((addr_o == 4'h5) ? 16'hDEAD : {12'h000, addr_o}) : mem[addr_o];

  always #5 clk_i = ~clk_i;

  mem_traffic_initiator dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .mode_i           (mode_i),
    .base_addr_i      (base_addr_i),
    .len_i            (len_i),
    .seed_i           (seed_i),
    .addr_o           (addr_o),
    .wdata_o          (wdata_o),
    .wr_rd_o          (wr_rd_o),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .rdata_i          (rdata_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .pass_o           (pass_o),
    .err_cnt_o        (err_cnt_o),
    .first_err_addr_o (first_err_addr_o)
`ifdef MEM_INIT_TIMEOUT_EN
    , .timeout_o      (timeout_o)
`endif
  );

  // Inputs change only 1 time unit after a rising edge, so the falling edge sees the
  // values that the next rising edge will sample.
  always @(negedge clk_i) begin
    if (valid_o) valid_cnt <= valid_cnt + 1;
    if (valid_o && ready_i) begin
      log_addr.push_back(addr_o);
      log_wr.push_back(wr_rd_o);
      log_data.push_back(wr_rd_o ? wdata_o : rdata_i);
      if (wr_rd_o) mem[addr_o] <= wdata_o;
      $display("xfer %s addr=%h data=%h t=%0t", wr_rd_o ? "wr" : "rd", addr_o,
               wr_rd_o ? wdata_o : rdata_i, $time);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_op(input logic [1:0] m, input logic [3:0] b, input logic [4:0] l,
                          input logic [15:0] s);
    start_i = 1'b1; mode_i = m; base_addr_i = b; len_i = l; seed_i = s;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (!done_o && cycles < budget) begin
      tick();
      cycles++;
    end
    if (!done_o) begin
      n_checks++; n_fail++;
      $display("FAIL wait_done: done_o=%b after %0d cycles, required 1", done_o, cycles);
    end
  endtask

  task automatic test_reset();
    #2 rst_i = 1'b0;
    tick(); tick();
    n_checks++;
    if ({valid_o, wr_rd_o, addr_o, wdata_o, busy_o, done_o, pass_o, err_cnt_o,
         first_err_addr_o} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b wr=%b addr=%h wdata=%h busy=%b done=%b pass=%b err=%h first=%h, required all 0",
               valid_o, wr_rd_o, addr_o, wdata_o, busy_o, done_o, pass_o, err_cnt_o, first_err_addr_o);
    end
    rst_i = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    int cyc;
    int lb;
    logic [3:0]  ea;
    logic [15:0] ed;
    lb = log_addr.size();
    ready_i = 1'b1;
    start_op(2'b10, 4'h0, 5'd16, 16'h1000);
    n_checks++;
    if (valid_o !== 1'b1) begin
      n_fail++; $display("FAIL first_valid: valid_o=%b required 1", valid_o);
    end
    wait_done(100, cyc);
    // Start cycle is cycle 1, first request cycle 2, so done lands in cycle 2 + cyc.
    n_checks++;
    if (cyc + 2 !== 34) begin
      n_fail++; $display("FAIL wr_rd_done_cycle: got cycle %0d required 34", cyc + 2);
    end
    n_checks++;
    if (pass_o !== 1'b1 || err_cnt_o !== 5'd0) begin
      n_fail++; $display("FAIL wr_rd_result: pass=%b err=%h required pass=1 err=0", pass_o, err_cnt_o);
    end
    n_checks++;
    if (log_addr.size() - lb !== 32) begin
      n_fail++; $display("FAIL wr_rd_count: got %0d transfers required 32", log_addr.size() - lb);
    end else begin
      for (int i = 0; i < 32; i++) begin
        ea = 4'(i % 16);
        ed = 16'h1000 + 16'(i % 16);
        n_checks++;
        if (log_addr[lb+i] !== ea || log_wr[lb+i] !== (i < 16) || log_data[lb+i] !== ed) begin
          n_fail++;
          $display("FAIL wr_rd_xfer%0d: addr=%h wr=%b data=%h required addr=%h wr=%b data=%h",
                   i, log_addr[lb+i], log_wr[lb+i], log_data[lb+i], ea, (i < 16), ed);
        end
      end
    end
    tick();
    n_checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || valid_o !== 1'b0) begin
      n_fail++; $display("FAIL done_pulse: done=%b busy=%b valid=%b required 0 0 0", done_o, busy_o, valid_o);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    int lb;
    logic [3:0] exp_a [4];
    exp_a[0] = 4'hE; exp_a[1] = 4'hF; exp_a[2] = 4'h0; exp_a[3] = 4'h1;
    lb = log_addr.size();
    start_op(2'b11, 4'hE, 5'd4, 16'h0100);
    wait_done(50, cyc);
    n_checks++;
    if (log_addr.size() - lb !== 8) begin
      n_fail++; $display("FAIL wrap_count: got %0d transfers required 8", log_addr.size() - lb);
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (log_addr[lb+i] !== exp_a[i%4] || log_wr[lb+i] !== (i < 4) ||
            log_data[lb+i] !== (16'h0100 + {12'h000, exp_a[i%4]})) begin
          n_fail++;
          $display("FAIL wrap_xfer%0d: addr=%h wr=%b data=%h required addr=%h wr=%b data=%h",
                   i, log_addr[lb+i], log_wr[lb+i], log_data[lb+i], exp_a[i%4], (i < 4),
                   16'h0100 + {12'h000, exp_a[i%4]});
        end
      end
    end
    n_checks++;
    if (pass_o !== 1'b1) begin
      n_fail++; $display("FAIL wrap_pass: pass=%b required 1", pass_o);
    end
    tick();
  endtask

  task automatic test_stall();
    int cyc;
    int lb;
    lb = log_addr.size();
    start_op(2'b00, 4'h3, 5'd4, 16'h0055);
    tick();            // first write (addr 3) accepted here
    ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (valid_o !== 1'b1 || wr_rd_o !== 1'b1 || addr_o !== 4'h4 || wdata_o !== 16'h0059) begin
        n_fail++;
        $display("FAIL stall_hold%0d: valid=%b wr=%b addr=%h wdata=%h required 1 1 4 0059",
                 k, valid_o, wr_rd_o, addr_o, wdata_o);
      end
      if (k == 3) ready_i = 1'b1;
      else tick();
    end
    n_checks++;
    if (log_addr.size() - lb !== 1) begin
      n_fail++; $display("FAIL stall_no_extra: got %0d transfers required 1", log_addr.size() - lb);
    end
    wait_done(50, cyc);
    n_checks++;
    if (log_addr.size() - lb !== 4 || log_addr[log_addr.size()-1] !== 4'h6 ||
        log_data[log_addr.size()-1] !== 16'h005B) begin
      n_fail++; $display("FAIL stall_total: got %0d transfers required 4 ending addr 6 data 005b",
                         log_addr.size() - lb);
    end
    n_checks++;
    if (pass_o !== 1'b1 || wr_rd_o !== 1'b1) begin
      n_fail++; $display("FAIL stall_end: pass=%b wr_rd=%b required 1 1", pass_o, wr_rd_o);
    end
    tick();
  endtask

  task automatic test_read_error();
    int cyc;
    int lb;
    int nwr;
    lb = log_addr.size();
    img_mode = 1'b1;
    start_op(2'b01, 4'h0, 5'd8, 16'h0000);
    wait_done(50, cyc);
    n_checks++;
    if (err_cnt_o !== 5'd1 || first_err_addr_o !== 4'h5 || pass_o !== 1'b0) begin
      n_fail++; $display("FAIL read_error: err=%h first=%h pass=%b required 01 5 0",
                         err_cnt_o, first_err_addr_o, pass_o);
    end
    nwr = 0;
    for (int i = lb; i < log_addr.size(); i++) if (log_wr[i]) nwr++;
    n_checks++;
    if (log_addr.size() - lb !== 8 || nwr !== 0 || cyc !== 8) begin
      n_fail++; $display("FAIL read_only_traffic: %0d transfers %0d writes %0d cycles required 8 0 8",
                         log_addr.size() - lb, nwr, cyc);
    end
    img_mode = 1'b0;
    tick();
  endtask

  task automatic test_len_zero();
    int vb;
    vb = valid_cnt;
    start_op(2'b10, 4'h2, 5'd0, 16'h1234);
    n_checks++;
    if (done_o !== 1'b1 || pass_o !== 1'b1) begin
      n_fail++; $display("FAIL len0_done: done=%b pass=%b required 1 1", done_o, pass_o);
    end
    tick(); tick();
    n_checks++;
    if (valid_cnt !== vb || done_o !== 1'b0) begin
      n_fail++; $display("FAIL len0_no_bus: valid cycles=%0d done=%b required 0 0", valid_cnt - vb, done_o);
    end
  endtask

  task automatic test_busy_start();
    int cyc;
    int lb;
    int vb;
    lb = log_addr.size();
    start_op(2'b10, 4'h0, 5'd4, 16'h0020);
    tick();
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_fail++; $display("FAIL busy_high: busy=%b required 1", busy_o);
    end
    start_op(2'b00, 4'h8, 5'd1, 16'h7777);
    wait_done(50, cyc);
    n_checks++;
    if (cyc !== 6 || log_addr.size() - lb !== 8 || log_addr[lb+1] !== 4'h1 ||
        log_data[lb+7] !== 16'h0023) begin
      n_fail++; $display("FAIL busy_ignore: cycles=%0d transfers=%0d required 6 8", cyc, log_addr.size() - lb);
    end
    vb = valid_cnt;
    for (int k = 0; k < 4; k++) tick();
    n_checks++;
    if (busy_o !== 1'b0 || valid_cnt !== vb) begin
      n_fail++; $display("FAIL busy_idle_after: busy=%b valid cycles=%0d required 0 0", busy_o, valid_cnt - vb);
    end
  endtask

`ifdef MEM_INIT_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    int lb;
    lb = log_addr.size();
    ready_i = 1'b0;
    start_op(2'b10, 4'h0, 5'd4, 16'h0000);
    wait_done(200, cyc);
    n_checks++;
    if (cyc !== 64 || timeout_o !== 1'b1 || pass_o !== 1'b0 || valid_o !== 1'b0 ||
        log_addr.size() !== lb) begin
      n_fail++; $display("FAIL timeout: cycles=%0d timeout=%b pass=%b valid=%b required 64 1 0 0",
                         cyc, timeout_o, pass_o, valid_o);
    end
    ready_i = 1'b1;
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    start_op(2'b10, 4'h0, 5'd16, 16'h0000);
    tick(); tick(); tick();
    #2 rst_i = 1'b0;
    #1;
    n_checks++;
    if ({valid_o, wr_rd_o, addr_o, wdata_o, busy_o, done_o, pass_o, err_cnt_o,
         first_err_addr_o} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b wr=%b addr=%h wdata=%h busy=%b required all 0",
               valid_o, wr_rd_o, addr_o, wdata_o, busy_o);
    end
    tick();
    rst_i = 1'b1;
    tick(); tick();
    n_checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_idle: valid=%b busy=%b required 0 0", valid_o, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_stall();
    test_read_error();
    test_len_zero();
    test_busy_start();
`ifdef MEM_INIT_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
